pedal_conditioner: RTL
======================

# pedal_conditioner

Front-end stage that turns raw, bouncy, asynchronous brake and accelerator pedal switches into clean single-cycle `brake` / `accelerate` request pulses for `car_speed_cntl`. Each pulse requests one speed step. Holding a pedal auto-repeats the request. Brake always has priority over accelerate, and the two outputs are never high together.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized samples required before a pedal level change is accepted; must be ≥ 1.
- `REPEAT_CYCLES`, default 16: clock cycles between auto-repeat pulses while a pedal is held; must be ≥ 2.
- `clock`  in  1  single clock for all state; rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `keys`  in  1  ignition; sampled synchronously; low = all requests suppressed.
- `brake_raw`  in  1  raw brake pedal switch, asynchronous, bouncy.
- `accel_raw`  in  1  raw accelerator pedal switch, asynchronous, bouncy.
- `brake`  out  1  registered single-cycle step-down request.
- `accelerate`  out  1  registered single-cycle step-up request.
- `brake_held`  out  1  registered debounced brake level, for status display.

## Operation
- Synchronizer: 2-flop synchronizer per raw pedal input.
- Debouncer, one per pedal: holds a `stable` level (reset 0) and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Each cycle that the synchronized value differs from `stable`, the counter increments.
  - Any cycle where they match, the counter clears.
  - When the counter would reach DEBOUNCE_CYCLES, `stable` flips and the counter clears.
- FSM states: IDLE, BRAKE, ACCEL. Reset state is IDLE.
  - IDLE: if brake_db, go to BRAKE and pulse `brake`. Else if accel_db, go to ACCEL and pulse `accelerate`. Else stay.
  - BRAKE: if !brake_db, go to IDLE with no pulse. Otherwise the repeat counter runs, and `brake` pulses each time it hits REPEAT_CYCLES-1; the counter then clears.
  - ACCEL: if brake_db, go to BRAKE and pulse `brake` immediately; the repeat counter clears (override). Else if !accel_db, go to IDLE. Else auto-repeat `accelerate` the same way as BRAKE.
- The repeat counter, width $clog2(REPEAT_CYCLES), clears on every state change.
- `keys` low: the FSM is forced to IDLE synchronously, the repeat counter clears, and `brake`/`accelerate` are 0. Debouncers keep running. When `keys` returns high with a pedal already debounced-held, that pedal is treated as a fresh press (pulse on the next edge).
- Invariant: `brake` & `accelerate` is never 1.

## Timing
- Reset values: `brake`=0, `accelerate`=0, `brake_held`=0. All synchronizer, debouncer and repeat state is cleared and the FSM is in IDLE. Outputs drop asynchronously on reset assertion.
- Reset mid-press: after deassertion, a still-held pedal goes through the full sync and debounce latency again before its first pulse.
- Press latency: let edge k be the first edge to sample raw high, with the raw input held clean. Then `stable` rises at edge k+DEBOUNCE_CYCLES+1, and the first pulse is high for exactly one cycle after edge k+DEBOUNCE_CYCLES+2 (k+6 at defaults).
- Repeat: with the first pulse at edge P, further pulses occur at P+REPEAT_CYCLES, P+2·REPEAT_CYCLES, … while the pedal is held.
- Release: no pulse is produced once `stable` falls. The FSM is in IDLE one edge later.
- Bounce: a glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no level change and no pulse.
- Simultaneous debounced press in IDLE: only `brake` pulses.
- Both pedals held in BRAKE: accelerate is ignored until brake releases; then the FSM goes to IDLE, and ACCEL is entered with a pulse on the following edge.
- `brake_held` equals brake `stable`, delayed by one register.

## Structure
- Shared package `car_ctrl_pkg`:
  - speed encodings STOP=2'b00, SLOW=2'b01, MEDIUM=2'b10, FAST=2'b11 (shared with `car_speed_cntl`);
  - `pedal_state_t` enum {IDLE, BRAKE, ACCEL}.
- Sub-module `pedal_debounce` (synchronizer + debounce counter, parameter DEBOUNCE_CYCLES), instantiated once per pedal.
- The top level holds the FSM, the repeat counter and the output registers.

## Test plan
All scenarios use defaults (D=4, R=16) with `keys`=1 unless noted.
- Clean press: `brake_raw` rises, first sampled at edge k and held 40 cycles -> `brake` pulses at k+6, k+22 and k+38. `accelerate` stays 0 and `brake_held` is 1 from k+6.
- Bounce: `accel_raw` toggles high 3 cycles, low 1, high 2, low and stays low -> no `accelerate` pulse, FSM remains IDLE.
- Override: accelerate held, with pulses at e and e+16. `brake_raw` rises so brake `stable` rises at edge f (e<f<e+16) -> `brake` pulses at f+1 and `accelerate` produces no further pulse.
- Simultaneous press: both raw inputs rise on the same edge k -> only `brake` at k+6. Release brake while accelerate is still held -> `accelerate` pulses 2 edges after brake `stable` falls.
- Ignition: hold accelerate and drop `keys` for 10 cycles -> no pulses during that window. `keys` high at edge m -> `accelerate` pulse at m+1.
- Async reset mid-repeat: assert `reset` between clock edges -> outputs 0 at once. After deassertion with the pedal held, the first pulse comes 6 edges after the first sampling edge.

Source files
------------

// File: rtl/car_ctrl_pkg.sv
// Shared definitions for the car control path: speed encodings used by
// car_speed_cntl and the pedal conditioner FSM state type.
package car_ctrl_pkg;

   // Speed encodings shared with car_speed_cntl.
   localparam logic [1:0] STOP   = 2'b00;
   localparam logic [1:0] SLOW   = 2'b01;
   localparam logic [1:0] MEDIUM = 2'b10;
   localparam logic [1:0] FAST   = 2'b11;

   // Pedal conditioner request FSM.
   //   IDLE  : no pedal being serviced
   //   BRAKE : brake held, auto-repeating brake requests
   //   ACCEL : accelerator held, auto-repeating accelerate requests
   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      BRAKE = 2'b01,
      ACCEL = 2'b10
   } pedal_state_t;

endpackage : car_ctrl_pkg

// File: rtl/pedal_debounce.sv
// Two-flop synchronizer followed by a stability debouncer for one raw
// pedal switch. The debounced level only changes after the synchronized
// input has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module pedal_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic stable
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [CW-1:0] cnt;

   // Bring the asynchronous switch into the clock domain.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Count consecutive disagreeing samples; flip the level when the count
   // would reach DEBOUNCE_CYCLES, and restart on any agreeing sample.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stable <= 1'b0;
         cnt    <= '0;
      end else if (sync2 != stable) begin
         if (cnt == LAST) begin
            stable <= ~stable;
            cnt    <= '0;
         end else begin
            cnt    <= cnt + CW'(1);
         end
      end else begin
         cnt <= '0;
      end
   end

endmodule : pedal_debounce

// File: rtl/pedal_conditioner.sv
// Turns bouncy asynchronous brake/accelerator switches into clean
// single-cycle step requests for car_speed_cntl, with auto-repeat while a
// pedal is held and brake always taking priority over accelerate.
//
// Request semantics: brake and accelerate are registered one-cycle pulses;
// each high cycle is exactly one step request, there is no back-pressure,
// and the two are never high in the same cycle.
module pedal_conditioner
   import car_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int REPEAT_CYCLES   = 16
) (
   input  logic clock,
   input  logic reset,
   input  logic keys,
   input  logic brake_raw,
   input  logic accel_raw,
   output logic brake,
   output logic accelerate,
   output logic brake_held
);

   localparam int RW = $clog2(REPEAT_CYCLES);
   localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_CYCLES - 1);

   logic          brake_db;
   logic          accel_db;

   pedal_state_t  state;
   pedal_state_t  state_nxt;
   logic [RW-1:0] rpt;
   logic [RW-1:0] rpt_nxt;
   logic          rpt_hit;
   logic          brake_nxt;
   logic          accel_nxt;

   pedal_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_brake_db (
      .clock  (clock),
      .reset  (reset),
      .raw    (brake_raw),
      .stable (brake_db)
   );

   pedal_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_accel_db (
      .clock  (clock),
      .reset  (reset),
      .raw    (accel_raw),
      .stable (accel_db)
   );

   assign rpt_hit = (rpt == RPT_LAST);

   // Next-state, repeat counter and request decode. The counter clears on
   // every state change and after each repeat pulse; ignition off parks
   // the FSM in IDLE so a pedal still held is seen as a fresh press later.
   always_comb begin
      state_nxt = state;
      rpt_nxt   = rpt;
      brake_nxt = 1'b0;
      accel_nxt = 1'b0;
      if (!keys) begin
         state_nxt = IDLE;
         rpt_nxt   = '0;
      end else begin
         case (state)
            IDLE: begin
               rpt_nxt = '0;
               if (brake_db) begin
                  state_nxt = BRAKE;
                  brake_nxt = 1'b1;
               end else if (accel_db) begin
                  state_nxt = ACCEL;
                  accel_nxt = 1'b1;
               end
            end
            BRAKE: begin
               if (!brake_db) begin
                  state_nxt = IDLE;
                  rpt_nxt   = '0;
               end else if (rpt_hit) begin
                  brake_nxt = 1'b1;
                  rpt_nxt   = '0;
               end else begin
                  rpt_nxt = rpt + RW'(1);
               end
            end
            ACCEL: begin
               if (brake_db) begin
                  // Brake overrides a held accelerator immediately.
                  state_nxt = BRAKE;
                  brake_nxt = 1'b1;
                  rpt_nxt   = '0;
               end else if (!accel_db) begin
                  state_nxt = IDLE;
                  rpt_nxt   = '0;
               end else if (rpt_hit) begin
                  accel_nxt = 1'b1;
                  rpt_nxt   = '0;
               end else begin
                  rpt_nxt = rpt + RW'(1);
               end
            end
            default: begin
               state_nxt = IDLE;
               rpt_nxt   = '0;
            end
         endcase
      end
   end

   // FSM state and repeat counter registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         rpt   <= '0;
      end else begin
         state <= state_nxt;
         rpt   <= rpt_nxt;
      end
   end

   // Registered request pulses and debounced brake level for display.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         brake      <= 1'b0;
         accelerate <= 1'b0;
         brake_held <= 1'b0;
      end else begin
         brake      <= brake_nxt;
         accelerate <= accel_nxt;
         brake_held <= brake_db;
      end
   end

endmodule : pedal_conditioner
